// File: rtl/addshift_arbiter.sv
// Two-requester round-robin front end sharing one (a + b) << SHIFT datapath,
// with a single-entry valid/ready result register and a handshake counter.
//
// state | meaning
// EMPTY | result register holds nothing, out_valid = 0
// FULL  | result register holds a result, out_valid = 1
module addshift_arbiter #(
   parameter int W     = 8,
   parameter int SHIFT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_result,
   output logic         out_id,
   output logic         out_ovf,
   output logic [15:0]  done_count
);

   localparam int WW = W + SHIFT + 1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t        state, state_nxt;
   logic          last_grant;
   logic          gnt_any, gnt_id;
   logic          space, accept, out_hs;
   logic [W-1:0]  op_a, op_b;
   logic [W:0]    sum;
   logic [WW-1:0] wide;
   logic [W:0]    res_nxt;
   logic          ovf_nxt;

   assign out_valid = (state == FULL);
   assign space     = !out_valid || out_ready;
   assign out_hs    = out_valid && out_ready;

   // On contention the requester that did not win last time gets the slot.
   assign gnt_any = req0_valid || req1_valid;
   assign gnt_id  = (req0_valid && req1_valid) ? !last_grant : req1_valid;

   assign req0_ready = space && gnt_any && !gnt_id;
   assign req1_ready = space && gnt_any && gnt_id;
   assign accept     = space && gnt_any;

   assign op_a = gnt_id ? req1_a : req0_a;
   assign op_b = gnt_id ? req1_b : req0_b;
   assign sum  = {1'b0, op_a} + {1'b0, op_b};

   // Widened shift keeps the bits pushed past the W+1 field so ovf can see them.
   assign wide    = WW'(sum) << SHIFT;
   assign res_nxt = wide[W:0];
   assign ovf_nxt = |(wide >> (W + 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (accept) state_nxt = FULL;
         FULL: begin
            if (accept)         state_nxt = FULL;
            else if (out_ready) state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result <= '0;
         out_id     <= 1'b0;
         out_ovf    <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         out_result <= res_nxt;
         out_id     <= gnt_id;
         out_ovf    <= ovf_nxt;
         last_grant <= gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_count <= '0;
      end else if (out_hs) begin
         done_count <= done_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_addshift_arbiter.sv
// Scoreboard bench for addshift_arbiter: SHIFT=1 and SHIFT=0 instances share
// stimulus; expected results are queued on accept and checked by a monitor.
module tb_addshift_arbiter;

   typedef struct {
      logic       id;
      logic [8:0] res;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v0 = 1'b0, v1 = 1'b0, out_ready = 1'b0;
   logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

   logic       r0, r1, ov, id, ovf;
   logic [8:0] res;
   logic [15:0] dc;
   logic       r0_z, r1_z, ov_z, id_z, ovf_z;
   logic [8:0] res_z;
   logic [15:0] dc_z;

   exp_t       q1[$];
   exp_t       q0[$];
   logic       last_m = 1'b1;
   logic [15:0] dc_m = '0;
   int         hs_total = 0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   addshift_arbiter #(.W(8), .SHIFT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
      .out_valid(ov), .out_ready(out_ready), .out_result(res),
      .out_id(id), .out_ovf(ovf), .done_count(dc)
   );

   addshift_arbiter #(.W(8), .SHIFT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_ready(r0_z), .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(r1_z), .req1_a(a1), .req1_b(b1),
      .out_valid(ov_z), .out_ready(out_ready), .out_result(res_z),
      .out_id(id_z), .out_ovf(ovf_z), .done_count(dc_z)
   );

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t calc(input logic [7:0] a, input logic [7:0] b,
                                 input int sh, input logic rid);
      exp_t e;
      int   s, w;
      s     = int'(a) + int'(b);
      w     = s << sh;
      e.id  = rid;
      e.res = w[8:0];
      e.ovf = (w >> 9) != 0;
      return e;
   endfunction

   // Monitor: compares the visible result against the queue head every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", int'(ov), int'(q1.size() != 0));
         chk("out_valid_s0", int'(ov_z), int'(q0.size() != 0));
         chk("done_count", int'(dc), int'(dc_m));
         chk("done_count_s0", int'(dc_z), int'(dc_m));
         if (q1.size() != 0) begin
            chk("out_result", int'(res), int'(q1[0].res));
            chk("out_id", int'(id), int'(q1[0].id));
            chk("out_ovf", int'(ovf), int'(q1[0].ovf));
            chk("out_result_s0", int'(res_z), int'(q0[0].res));
            chk("out_ovf_s0", int'(ovf_z), int'(q0[0].ovf));
            if (out_ready) begin
               void'(q1.pop_front());
               void'(q0.pop_front());
               dc_m = dc_m + 16'd1;
               hs_total++;
            end
         end
      end
   end

   // One cycle: predict grant from the round-robin rule, check readies,
   // queue the expected result of an accept, then retire the accepted pair.
   task automatic tick();
      logic space, any, g, acc0, acc1;
      @(negedge clk);
      #1;
      space = (q1.size() == 0);
      any   = v0 || v1;
      g     = (v0 && v1) ? !last_m : v1;
      acc0  = space && any && !g;
      acc1  = space && any && g;
      chk("req0_ready", int'(r0), int'(acc0));
      chk("req1_ready", int'(r1), int'(acc1));
      chk("req0_ready_s0", int'(r0_z), int'(acc0));
      chk("req1_ready_s0", int'(r1_z), int'(acc1));
      if (acc0) begin
         q1.push_back(calc(a0, b0, 1, 1'b0));
         q0.push_back(calc(a0, b0, 0, 1'b0));
         last_m = 1'b0;
      end else if (acc1) begin
         q1.push_back(calc(a1, b1, 1, 1'b1));
         q0.push_back(calc(a1, b1, 0, 1'b1));
         last_m = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc0) v0 = 1'b0;
      if (acc1) v1 = 1'b0;
   endtask

   task automatic load0(input logic [7:0] a, input logic [7:0] b);
      v0 = 1'b1; a0 = a; b0 = b;
   endtask

   task automatic load1(input logic [7:0] a, input logic [7:0] b);
      v1 = 1'b1; a1 = a; b1 = b;
   endtask

   initial begin
      int n;
      #2;
      chk("rst_out_valid", int'(ov), 0);
      chk("rst_out_result", int'(res), 0);
      chk("rst_out_id", int'(id), 0);
      chk("rst_out_ovf", int'(ovf), 0);
      chk("rst_done_count", int'(dc), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed operand cases
      out_ready = 1'b1;
      load0(8'h00, 8'h80);
      tick();
      tick();
      load1(8'hFF, 8'hFF);
      tick();
      tick();

      // Continuous contention
      for (int i = 0; i < 6; i++) begin
         if (!v0) load0(8'($urandom), 8'($urandom));
         if (!v1) load1(8'($urandom), 8'($urandom));
         tick();
      end
      v0 = 1'b0; v1 = 1'b0;
      tick();

      // Backpressure then release with a pending requester
      load0(8'h12, 8'h34);
      tick();
      out_ready = 1'b0;
      load0(8'h55, 8'hAA);
      load1(8'h80, 8'h80);
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b1;
      tick();
      tick();
      tick();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (!v0 && ($urandom_range(0, 2) != 0)) load0(8'($urandom), 8'($urandom));
         if (!v1 && ($urandom_range(0, 2) != 0)) load1(8'($urandom), 8'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Stream until done_count wraps past 0xFFFF to 0x0001
      out_ready = 1'b1;
      n = 0;
      while (hs_total < 65537 && n < 70000) begin
         if (!v0) load0(8'($urandom), 8'($urandom));
         if (!v1) load1(8'($urandom), 8'($urandom));
         tick();
         n++;
      end
      chk("stream_budget", int'(hs_total >= 65537), 1);
      v0 = 1'b0; v1 = 1'b0;
      tick();
      tick();

      // Reset while FULL under backpressure
      out_ready = 1'b0;
      load1(8'h11, 8'h22);
      tick();
      tick();
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      #1;
      chk("midrst_out_valid", int'(ov), 0);
      chk("midrst_done_count", int'(dc), 0);
      chk("midrst_req0_ready", int'(r0), 0);
      chk("midrst_req1_ready", int'(r1), 0);
      q1.delete();
      q0.delete();
      last_m = 1'b1;
      dc_m = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      load0(8'h01, 8'h02);
      load1(8'h03, 8'h04);
      tick();
      tick();
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
